cart_auth_host: RTL and testbench

- Console-side initiator and receiver for the cartridge mapper unlock/authentication protocol.
- Drives the two-step unlock address sequence (5Ah, then A5h) onto the cartridge address bus.
- Captures the 18-bit serial frame the cartridge returns on its synchronous out pin and checks the 16-bit payload against an expected word.
- On a match, sets the SYSTEM_CTRL1 bit-7 enable; otherwise reports failure.

---
 rtl/cart_auth_host.sv | 210 +++++++++++++++++++++
 tb/tb_cart_auth_host.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cart_auth_host.sv
// cart_auth_host
//   Console-side initiator/receiver for the cartridge mapper unlock sequence.
//   Drives the 5Ah/A5h unlock addresses, captures the 18-bit serial frame
//   returned on SI (start 0, 16-bit payload LSB first, trailer 0), compares
//   the payload with EXPECT and latches the sticky SYSTEM_CTRL1 bit-7 enable
//   on success.
//
// Ports:
//   CLK          system clock (shared with the cartridge mapper)
//   RSTn         asynchronous active-low reset
//   START        one-cycle request; only accepted while idle
//   SI           serial frame from cartridge SO (CLK-synchronous, idle high)
//   ADDR_O       unlock address byte, valid while ADDR_OE=1
//   ADDR_OE      address bus ownership (ACK/NAK states only)
//   CART_RSTn    cartridge reset drive, active low
//   BUSY         sequence in progress
//   DONE         one-cycle completion pulse
//   PASS         result, valid with DONE, held until next accepted START
//   WORD         captured payload, valid with DONE, held until next START
//   SYS_CTRL1_B7 sticky enable, set on PASS, cleared only by RSTn
//
// Optional build macro: CART_AUTH_RETRY_EN
//   When defined, a failed attempt pulses CART_RSTn low for 2 cycles, high
//   for 1 cycle, and re-runs the sequence up to MAX_RETRY times.
module cart_auth_host #(
  parameter logic [15:0] EXPECT    = 16'h28A0,
  parameter int unsigned TIMEOUT   = 8,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        START,
  input  logic        SI,
  output logic [7:0]  ADDR_O,
  output logic        ADDR_OE,
  output logic        CART_RSTn,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [15:0] WORD,
  output logic        SYS_CTRL1_B7
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACK,
    S_NAK,
    S_WAIT,
    S_SHIFT,
    S_TRAIL,
`ifdef CART_AUTH_RETRY_EN
    S_RLO,
    S_RHI,
`endif
    S_FIN
  } state_t;

  state_t        state, nstate;
  logic [TW-1:0] tcnt;
  logic [3:0]    bcnt;
  logic [15:0]   word_q;
  logic          pass_q;
  logic          b7_q;

  logic [7:0]    addr_c;
  logic          oe_c, busy_c, done_c, crst_c;

`ifdef CART_AUTH_RETRY_EN
  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_q;
  logic          rcnt;
  logic          retry_take;

  // A failing result in FIN is retried while attempts remain.
  assign retry_take = !pass_q && (32'(retry_q) < MAX_RETRY);
`else
  logic [31:0]   unused_max_retry;
  assign unused_max_retry = MAX_RETRY;
`endif

  // Next-state and output decode
  always_comb begin
    nstate = state;
    addr_c = '0;
    oe_c   = 1'b0;
    busy_c = 1'b1;
    done_c = 1'b0;
    crst_c = 1'b1;
    case (state)
      S_IDLE: begin
        busy_c = 1'b0;
        if (START) nstate = S_ACK;
      end
      S_ACK: begin
        addr_c = 8'h5A;
        oe_c   = 1'b1;
        nstate = S_NAK;
      end
      S_NAK: begin
        addr_c = 8'hA5;
        oe_c   = 1'b1;
        nstate = S_WAIT;
      end
      S_WAIT: begin
        if (!SI)                           nstate = S_SHIFT;
        else if (tcnt == TW'(TIMEOUT - 1)) nstate = S_FIN;
      end
      S_SHIFT: begin
        if (bcnt == 4'hF) nstate = S_TRAIL;
      end
      S_TRAIL: nstate = S_FIN;
`ifdef CART_AUTH_RETRY_EN
      S_FIN: begin
        if (retry_take) begin
          nstate = S_RLO;
        end else begin
          done_c = 1'b1;
          busy_c = 1'b0;
          nstate = S_IDLE;
        end
      end
      S_RLO: begin
        crst_c = 1'b0;
        if (rcnt) nstate = S_RHI;
      end
      S_RHI: nstate = S_ACK;
`else
      S_FIN: begin
        done_c = 1'b1;
        busy_c = 1'b0;
        nstate = S_IDLE;
      end
`endif
      default: begin
        busy_c = 1'b0;
        nstate = S_IDLE;
      end
    endcase
  end

  // State register and datapath
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state  <= S_IDLE;
      tcnt   <= '0;
      bcnt   <= '0;
      word_q <= '0;
      pass_q <= 1'b0;
      b7_q   <= 1'b0;
`ifdef CART_AUTH_RETRY_EN
      retry_q <= '0;
      rcnt    <= 1'b0;
`endif
    end else begin
      state <= nstate;
      case (state)
        S_IDLE: begin
          if (START) begin
            pass_q <= 1'b0;
            word_q <= '0;
`ifdef CART_AUTH_RETRY_EN
            retry_q <= '0;
`endif
          end
        end
        S_NAK: begin
          tcnt <= '0;
          bcnt <= '0;
        end
        S_WAIT: begin
          if (SI) tcnt <= tcnt + 1'b1;
        end
        S_SHIFT: begin
          // LSB arrives first; after 16 shifts it sits at bit 0.
          word_q <= {SI, word_q[15:1]};
          bcnt   <= bcnt + 1'b1;
        end
        S_TRAIL: begin
          // Result is resolved here so PASS and the enable are already
          // valid during the DONE cycle.
          if (!SI && (word_q == EXPECT)) begin
            pass_q <= 1'b1;
            b7_q   <= 1'b1;
          end
        end
`ifdef CART_AUTH_RETRY_EN
        S_FIN: rcnt <= 1'b0;
        S_RLO: rcnt <= 1'b1;
        S_RHI: begin
          retry_q <= retry_q + 1'b1;
          word_q  <= '0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign ADDR_O       = addr_c;
  assign ADDR_OE      = oe_c;
  assign CART_RSTn    = crst_c;
  assign BUSY         = busy_c;
  assign DONE         = done_c;
  assign PASS         = pass_q;
  assign WORD         = word_q;
  assign SYS_CTRL1_B7 = b7_q;

endmodule

// File: tb/tb_cart_auth_host.sv
module tb_cart_auth_host;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        START = 1'b0;
  logic        SI = 1'b1;
  logic [7:0]  ADDR_O;
  logic        ADDR_OE;
  logic        CART_RSTn;
  logic        BUSY;
  logic        DONE;
  logic        PASS;
  logic [15:0] WORD;
  logic        SYS_CTRL1_B7;

  localparam int MAXR = 3;

  always #5 CLK = ~CLK;

  cart_auth_host #(
    .EXPECT   (16'h28A0),
    .TIMEOUT  (8),
    .MAX_RETRY(3)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .START       (START),
    .SI          (SI),
    .ADDR_O      (ADDR_O),
    .ADDR_OE     (ADDR_OE),
    .CART_RSTn   (CART_RSTn),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .PASS        (PASS),
    .WORD        (WORD),
    .SYS_CTRL1_B7(SYS_CTRL1_B7)
  );

  typedef struct {
    logic [15:0] payload;
    logic        trailer;
    int          stuck;     // leading attempts in which the cart stays silent
    logic [15:0] exp_word;
    logic        exp_pass;
    logic        exp_b7;
  } vec_t;

  typedef struct {
    logic [15:0] word;
    logic        pass;
    logic        b7;
    int          done_k;
    int          rst_lo;
  } exp_t;

  exp_t sb[$];
  vec_t vt[8];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Negedge index (after edge E0) at which DONE is expected, and the number
  // of CART_RSTn-low cycles seen before it.
  task automatic predict(input int stuck, input logic ok, output int dk, output int rl);
`ifdef CART_AUTH_RETRY_EN
    int  off = 0;
    int  a = 0;
    bit  fin = 0;
    dk = 0;
    rl = 0;
    while (!fin) begin
      if (a < stuck) begin
        if (a < MAXR) begin off += 14; a++; rl += 2; end
        else begin dk = off + 10; fin = 1; end
      end else if (ok) begin
        dk = off + 20; fin = 1;
      end else if (a < MAXR) begin
        off += 24; a++; rl += 2;
      end else begin
        dk = off + 20; fin = 1;
      end
    end
`else
    dk = (stuck > 0) ? 10 : 20;
    rl = 0;
`endif
  endtask

  task automatic run_vec(input vec_t v, input int restart_k, input bit start_at_fin);
    exp_t        e, got_e;
    int          dk, rl, attempt, pos, rst_lo_seen;
    bit          got;
    logic [17:0] frame;
    frame = {v.trailer, v.payload, 1'b0};
    predict(v.stuck, v.exp_pass, dk, rl);
    e = '{v.exp_word, v.exp_pass, v.exp_b7, dk, rl};
    @(negedge CLK);
    START = 1'b1;
    SI    = 1'b1;
    sb.push_back(e);
    attempt = 0; pos = 18; got = 0; rst_lo_seen = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge CLK);
      START = (restart_k >= 0 && k == restart_k);
      if (k == 0) begin
        chk("addr_ack", 32'(ADDR_O), 32'h5A);
        chk("oe_ack",   32'(ADDR_OE), 32'h1);
        chk("busy_run", 32'(BUSY), 32'h1);
      end
      if (k == 1) begin
        chk("addr_nak", 32'(ADDR_O), 32'hA5);
        chk("oe_nak",   32'(ADDR_OE), 32'h1);
      end
      if (k == 2) begin
        chk("addr_wait", 32'(ADDR_O), 32'h00);
        chk("oe_wait",   32'(ADDR_OE), 32'h0);
      end
      if (!CART_RSTn) rst_lo_seen++;
      if (DONE) begin
        got   = 1;
        got_e = sb.pop_front();
        chk("word",     32'(WORD), 32'(got_e.word));
        chk("pass",     32'(PASS), 32'(got_e.pass));
        chk("b7",       32'(SYS_CTRL1_B7), 32'(got_e.b7));
        chk("done_cyc", 32'(k), 32'(got_e.done_k));
        chk("rst_lo",   32'(rst_lo_seen), 32'(got_e.rst_lo));
        chk("busy_fin", 32'(BUSY), 32'h0);
      end
      // Cartridge model: frame is loaded when the A5h address is seen.
      if (ADDR_OE && ADDR_O == 8'hA5) begin
        attempt++;
        pos = (attempt > v.stuck) ? 0 : 18;
        SI  = 1'b1;
      end else if (pos < 18) begin
        SI = frame[pos];
        pos++;
      end else begin
        SI = 1'b1;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no DONE expected DONE at %0d", dk);
      void'(sb.pop_front());
    end
    if (start_at_fin) START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("done_pulse", 32'(DONE), 32'h0);
    chk("busy_after", 32'(BUSY), 32'h0);
    chk("oe_after",   32'(ADDR_OE), 32'h0);
    @(negedge CLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  32'(ADDR_O), 32'h00);
    chk({tag, "_oe"},    32'(ADDR_OE), 32'h0);
    chk({tag, "_crst"},  32'(CART_RSTn), 32'h1);
    chk({tag, "_busy"},  32'(BUSY), 32'h0);
    chk({tag, "_done"},  32'(DONE), 32'h0);
    chk({tag, "_pass"},  32'(PASS), 32'h0);
    chk({tag, "_word"},  32'(WORD), 32'h0000);
    chk({tag, "_b7"},    32'(SYS_CTRL1_B7), 32'h0);
  endtask

  initial begin
    int dones;
    vt[0] = '{16'h28A1, 1'b0, 0,  16'h28A1, 1'b0, 1'b0};
    vt[1] = '{16'h28A0, 1'b0, 99, 16'h0000, 1'b0, 1'b0};
    vt[2] = '{16'h28A0, 1'b0, 0,  16'h28A0, 1'b1, 1'b1};
    vt[3] = '{16'h28A0, 1'b1, 0,  16'h28A0, 1'b0, 1'b1};
    vt[4] = '{16'hA028, 1'b0, 0,  16'hA028, 1'b0, 1'b1};
    vt[5] = '{16'h0000, 1'b0, 0,  16'h0000, 1'b0, 1'b1};
    vt[6] = '{16'hFFFF, 1'b1, 0,  16'hFFFF, 1'b0, 1'b1};
    vt[7] = '{16'h28A0, 1'b0, 0,  16'h28A0, 1'b1, 1'b1};

    repeat (3) @(negedge CLK);
    chk_reset_vals("rst0");
    RSTn = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 8; i++) run_vec(vt[i], -1, 1'b0);

    // START re-pulsed mid-run and again in the FIN cycle: both ignored.
    run_vec('{16'h28A0, 1'b0, 0, 16'h28A0, 1'b1, 1'b1}, 4, 1'b1);

`ifdef CART_AUTH_RETRY_EN
    // Silent first attempt, good cartridge afterwards.
    run_vec('{16'h28A0, 1'b0, 1, 16'h28A0, 1'b1, 1'b1}, -1, 1'b0);
`endif

    // Reset mid-operation: cart silent, START re-pulsed, RSTn before timeout.
    @(negedge CLK);
    START = 1'b1;
    SI    = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK);
      START = (k == 4);
    end
    RSTn = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(negedge CLK);
    RSTn  = 1'b1;
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'h0);
    chk("abort_idle",    32'(BUSY), 32'h0);
    chk("sb_empty",      32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
